cla_pipe_adder: RTL and testbench

- Parametrised two-stage pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups with a second-level group lookahead.
- Successor to the single-level 4-bit lookahead carry unit: generalised in width, registered, supports add/sub modes and status flags.
- Sits between the operand-issue logic and the ALU result mux.
- Uses a valid/ready handshake on both sides, with full back-pressure.

---
 rtl/cla_pipe_adder.sv | 169 ++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with 4-bit groups, a second-level
// group lookahead and valid/ready handshaking. Optional saturation under CLA_PIPE_SAT_EN.
module cla_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef CLA_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int GROUPS = WIDTH / 4;

  if ((WIDTH % 4 != 0) || (WIDTH < 4) || (WIDTH > 64)) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 in 4..64");
  end

  // Handshake
  logic s1_valid_q, out_valid_q;
  logic s2_ready, s1_load, s2_load;

  assign s2_ready = !out_valid_q | out_ready;
  assign in_ready = !s1_valid_q | s2_ready;
  assign s1_load  = in_valid & in_ready;
  assign s2_load  = s1_valid_q & s2_ready;

  // Stage 1: operand conditioning and per-bit / per-group propagate-generate
  logic [WIDTH-1:0]  b_eff, p_d, g_d, p_q, g_q;
  logic [GROUPS-1:0] gp_d, gg_d, gp_q, gg_q;
  logic              c0_d, c0_q;
`ifdef CLA_PIPE_SAT_EN
  logic              sat_q;
`endif

  // NOTE: every variable written in always_comb is assigned unconditionally first so no latch is inferred.
  always_comb begin
    b_eff = sub ? ~b : b;
    c0_d  = sub | cin;
    p_d   = a ^ b_eff;
    g_d   = a & b_eff;
    gp_d  = '0;
    gg_d  = '0;
    for (int k = 0; k < GROUPS; k++) begin
      gp_d[k] = &p_d[4*k +: 4];
      gg_d[k] = g_d[4*k+3]
              | (p_d[4*k+3] & g_d[4*k+2])
              | (p_d[4*k+3] & p_d[4*k+2] & g_d[4*k+1])
              | (p_d[4*k+3] & p_d[4*k+2] & p_d[4*k+1] & g_d[4*k]);
    end
  end

  // NOTE: data registers are reset too because the cleared output values are architecturally visible.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      gp_q       <= '0;
      gg_q       <= '0;
      c0_q       <= 1'b0;
`ifdef CLA_PIPE_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      if (s1_load) begin
        s1_valid_q <= 1'b1;
        p_q        <= p_d;
        g_q        <= g_d;
        gp_q       <= gp_d;
        gg_q       <= gg_d;
        c0_q       <= c0_d;
`ifdef CLA_PIPE_SAT_EN
        sat_q      <= sat;
`endif
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  // Stage 2: group-level lookahead, intra-group carries, sum and flags
  logic [GROUPS:0]  grp_c;
  logic [WIDTH-1:0] bit_c, sum_raw, sum_d;
  logic             chain, cout_d, ovf_d, zero_d;

  always_comb begin
    grp_c    = '0;
    grp_c[0] = c0_q;
    chain    = 1'b0;
    for (int k = 1; k <= GROUPS; k++) begin
      // Sum-of-products form: each lower group's generate, propagated through the groups above it.
      chain = c0_q;
      for (int j = 0; j < k; j++) chain = chain & gp_q[j];
      grp_c[k] = chain;
      for (int j = 0; j < k; j++) begin
        chain = gg_q[j];
        for (int m = j + 1; m < k; m++) chain = chain & gp_q[m];
        grp_c[k] = grp_c[k] | chain;
      end
    end

    bit_c = '0;
    for (int k = 0; k < GROUPS; k++) begin
      bit_c[4*k]   = grp_c[k];
      bit_c[4*k+1] = g_q[4*k] | (p_q[4*k] & grp_c[k]);
      bit_c[4*k+2] = g_q[4*k+1] | (p_q[4*k+1] & g_q[4*k])
                   | (p_q[4*k+1] & p_q[4*k] & grp_c[k]);
      bit_c[4*k+3] = g_q[4*k+2] | (p_q[4*k+2] & g_q[4*k+1])
                   | (p_q[4*k+2] & p_q[4*k+1] & g_q[4*k])
                   | (p_q[4*k+2] & p_q[4*k+1] & p_q[4*k] & grp_c[k]);
    end

    sum_raw = p_q ^ bit_c;
    cout_d  = grp_c[GROUPS];
    ovf_d   = bit_c[WIDTH-1] ^ cout_d;
    sum_d   = sum_raw;
`ifdef CLA_PIPE_SAT_EN
    // A wrapped negative result means the true result overflowed positively, and vice versa.
    if (sat_q && ovf_d) begin
      sum_d = sum_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
    zero_d = ~|sum_d;
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid_q <= 1'b1;
        sum_q       <= sum_d;
        cout_q      <= cout_d;
        ovf_q       <= ovf_d;
        zero_q      <= zero_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16): directed cases, back-pressure,
// full-rate random stream, random handshakes and reset mid-stream against an arithmetic model.
module tb_cla_pipe_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, sub, sat, cout, ovf, zero;

  cla_pipe_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef CLA_PIPE_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           acc;
  } res_t;

  res_t         exp_q[$];
  logic [W-1:0] out_log[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  bit           chk_lat = 0;
  bit           last_acc;
  logic [W-1:0] last_sum;
  logic         last_cout, last_ovf, last_zero;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the true signed and unsigned results.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb, input logic st);
    res_t         r;
    logic [W-1:0] ny;
    logic [W:0]   full;
    longint       sres;
    ny = ~y;
    if (sb) begin
      full = {1'b0, x} + {1'b0, ny} + 17'd1;
      sres = longint'($signed(x)) - longint'($signed(y));
    end else begin
      full = {1'b0, x} + {1'b0, y} + {16'd0, ci};
      sres = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    end
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (sres > 32767) || (sres < -32768);
`ifdef CLA_PIPE_SAT_EN
    if (st && r.ovf) r.sum = (sres > 0) ? 16'h7FFF : 16'h8000;
`else
    if (st) r.sum = r.sum;
`endif
    r.zero = (r.sum == '0);
    r.acc  = 0;
    return r;
  endfunction

  // One clock: observe both handshakes just before the rising edge, then move to the next falling edge.
  task automatic tick();
    res_t r;
    #1;
    cyc++;
    last_acc = 1'b0;
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_out: observed=%0h expected=none", sum);
      end
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        check("sum", 32'(sum), 32'(r.sum));
        check("cout", 32'(cout), 32'(r.cout));
        check("ovf", 32'(ovf), 32'(r.ovf));
        check("zero", 32'(zero), 32'(r.zero));
        if (chk_lat) check("latency", cyc - r.acc, 2);
      end
      last_sum  = sum;
      last_cout = cout;
      last_ovf  = ovf;
      last_zero = zero;
      out_log.push_back(sum);
    end
    if (in_valid && in_ready) begin
      r     = model(a, b, cin, sub, sat);
      r.acc = cyc;
      exp_q.push_back(r);
      last_acc = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic run_dir(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic sb, input logic st,
                         input logic [W-1:0] e_sum, input logic e_cout,
                         input logic e_ovf, input logic e_zero);
    a = x; b = y; cin = ci; sub = sb; sat = st;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    drain();
    check({tag, "_sum"}, 32'(last_sum), 32'(e_sum));
    check({tag, "_cout"}, 32'(last_cout), 32'(e_cout));
    check({tag, "_ovf"}, 32'(last_ovf), 32'(e_ovf));
    check({tag, "_zero"}, 32'(last_zero), 32'(e_zero));
  endtask

  initial begin
    int base;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_flags", {29'd0, cout, ovf, zero}, 0);
    check("rst_in_ready", 32'(in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic
    chk_lat = 1;
    run_dir("add", 16'h1234, 16'h0FCD, 1'b1, 1'b0, 1'b0, 16'h2202, 1'b0, 1'b0, 1'b0);
    run_dir("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_dir("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_dir("subcin", 16'h0005, 16'h0005, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
`ifdef CLA_PIPE_SAT_EN
    run_dir("satneg", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
    run_dir("satpos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
`endif

    // Back-pressure: three beats into a stalled output
    chk_lat = 0;
    out_log.delete();
    out_ready = 1'b0; sub = 1'b0; cin = 1'b0; sat = 1'b0; in_valid = 1'b1;
    a = 16'd1; b = 16'd1;
    tick();
    check("bp_acc1", 32'(last_acc), 1);
    a = 16'd2; b = 16'd2;
    tick();
    check("bp_acc2", 32'(last_acc), 1);
    a = 16'd3; b = 16'd3;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("bp_in_ready_low", 32'(in_ready), 0);
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_sum", 32'(sum), 2);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && !last_acc; i++) tick();
    check("bp_acc3", 32'(last_acc), 1);
    drain();
    check("bp_count", out_log.size(), 3);
    if (out_log.size() == 3) begin
      check("bp_order0", 32'(out_log[0]), 2);
      check("bp_order1", 32'(out_log[1]), 4);
      check("bp_order2", 32'(out_log[2]), 6);
    end

    // Full-rate stream: one result per cycle after a two-cycle fill
    chk_lat = 1;
    base = out_log.size();
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      a = W'($urandom); b = W'($urandom);
      cin = 1'($urandom); sub = 1'($urandom); sat = 1'($urandom);
      in_valid = 1'b1;
      #1;
      check("tp_in_ready", 32'(in_ready), 1);
      check("tp_out_valid", 32'(out_valid), (k >= 2) ? 1 : 0);
      tick();
    end
    drain();
    check("tp_count", out_log.size() - base, 100);

    // Random handshakes on both sides
    chk_lat = 0;
    for (int k = 0; k < 300; k++) begin
      a = W'($urandom); b = W'($urandom);
      if (($urandom % 8) == 0) b = W'(16'h8000 - a);
      cin = 1'($urandom); sub = 1'($urandom); sat = 1'($urandom);
      in_valid  = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      tick();
    end
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0; sub = 1'b0; cin = 1'b0; sat = 1'b0;
    a = 16'h0101; b = 16'h0202; in_valid = 1'b1;
    tick();
    a = 16'h0303; b = 16'h0404;
    tick();
    in_valid = 1'b0;
    #1;
    check("pre_rst_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_sum", 32'(sum), 0);
    check("mid_rst_flags", {29'd0, cout, ovf, zero}, 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_lat = 1;
    run_dir("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
